store_check_monitor: RTL and testbench



---
 rtl/store_check_monitor.sv | 153 +++++++++++++++
 tb/tb_store_check_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_check_monitor.sv
// store_check_monitor: watches the data-memory store bus of the single-cycle
// MIPS core and latches a sticky pass / fail / timeout verdict. Every output
// comes straight from a flip-flop.
module store_check_monitor #(
    parameter logic [31:0] PASS_ADDR      = 32'd84,
    parameter logic [31:0] PASS_DATA      = 32'd7,
    parameter logic [31:0] IGNORE_ADDR    = 32'd80,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [31:0]      dataadr,
    input  logic [31:0]      writedata,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [CNT_W-1:0] store_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [31:0]      err_addr,
    output logic [31:0]      err_data
);

    // The timeout counter is separate from the saturating cycle counter, so a
    // narrow CNT_W can never hide or delay the timeout.
    localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW:0] TMO_VAL = TIMEOUT_CYCLES[TW:0];

    typedef enum logic [1:0] {
        st_run     = 2'd0,
        st_pass    = 2'd1,
        st_fail    = 2'd2,
        st_timeout = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] store_count_r;
    logic [CNT_W-1:0] cycle_count_r;
    logic [CNT_W-1:0] store_count_next_s;
    logic [CNT_W-1:0] cycle_count_next_s;
    logic [TW-1:0]    tmo_cnt_r;
    logic [TW-1:0]    tmo_cnt_next_s;
    logic [TW:0]      tmo_inc_s;
    logic             tmo_hit_s;
    logic [31:0]      err_addr_r;
    logic [31:0]      err_data_r;
    logic [31:0]      err_addr_next_s;
    logic [31:0]      err_data_next_s;
    logic             done_r;
    logic             pass_r;
    logic             fail_r;
    logic             timeout_r;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Timeout fires on the edge that would bring the run count to TIMEOUT_CYCLES.
    always_comb begin
        tmo_inc_s = {1'b0, tmo_cnt_r} + {{TW{1'b0}}, 1'b1};
        tmo_hit_s = (tmo_inc_s == TMO_VAL);
    end

    // Next-state, counter and capture logic; a store verdict beats a timeout.
    always_comb begin
        state_next_s       = state_r;
        store_count_next_s = store_count_r;
        cycle_count_next_s = cycle_count_r;
        tmo_cnt_next_s     = tmo_cnt_r;
        err_addr_next_s    = err_addr_r;
        err_data_next_s    = err_data_r;
        case (state_r)
            st_run: begin
                cycle_count_next_s = sat_inc(cycle_count_r);
                tmo_cnt_next_s     = tmo_inc_s[TW-1:0];
                if (memwrite == 1'b1) begin
                    store_count_next_s = sat_inc(store_count_r);
                    if (dataadr[1:0] != 2'b00) begin
                        state_next_s = st_fail;
                    end else if ((dataadr == PASS_ADDR) && (writedata == PASS_DATA)) begin
                        state_next_s = st_pass;
                    end else if (dataadr == IGNORE_ADDR) begin
                        state_next_s = st_run;
                    end else begin
                        state_next_s = st_fail;
                    end
                    if (state_next_s != st_run) begin
                        err_addr_next_s = dataadr;
                        err_data_next_s = writedata;
                    end else begin
                        err_addr_next_s = err_addr_r;
                        err_data_next_s = err_data_r;
                    end
                end else if (tmo_hit_s) begin
                    state_next_s = st_timeout;
                end else begin
                    state_next_s = st_run;
                end
            end
            default: begin
                // Terminal verdicts absorb everything until reset.
                state_next_s = state_r;
            end
        endcase
    end

    // State, counters, captured store and decoded verdict flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= st_run;
            store_count_r <= {CNT_W{1'b0}};
            cycle_count_r <= {CNT_W{1'b0}};
            tmo_cnt_r     <= {TW{1'b0}};
            err_addr_r    <= 32'd0;
            err_data_r    <= 32'd0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            fail_r        <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            store_count_r <= store_count_next_s;
            cycle_count_r <= cycle_count_next_s;
            tmo_cnt_r     <= tmo_cnt_next_s;
            err_addr_r    <= err_addr_next_s;
            err_data_r    <= err_data_next_s;
            done_r        <= (state_next_s != st_run);
            pass_r        <= (state_next_s == st_pass);
            fail_r        <= (state_next_s == st_fail);
            timeout_r     <= (state_next_s == st_timeout);
        end
    end

    assign done        = done_r;
    assign pass        = pass_r;
    assign fail        = fail_r;
    assign timeout     = timeout_r;
    assign store_count = store_count_r;
    assign cycle_count = cycle_count_r;
    assign err_addr    = err_addr_r;
    assign err_data    = err_data_r;

endmodule

// File: tb/tb_store_check_monitor.sv
// Scoreboard bench for store_check_monitor: stimulus pushes the expected
// verdict, a negedge monitor pops it when done rises and compares everything.
module tb_store_check_monitor;

    localparam int TMO = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        done, pass, fail, timeout;
    logic [15:0] store_count, cycle_count;
    logic [31:0] err_addr, err_data;

    typedef struct {
        logic        p;
        logic        f;
        logic        t;
        logic [15:0] sc;
        logic [15:0] cc;
        logic [31:0] ea;
        logic [31:0] ed;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done_q = 1'b0;

    store_check_monitor #(
        .PASS_ADDR(32'd84), .PASS_DATA(32'd7), .IGNORE_ADDR(32'd80),
        .TIMEOUT_CYCLES(TMO), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .store_count(store_count), .cycle_count(cycle_count),
        .err_addr(err_addr), .err_data(err_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic p, input logic f, input logic t, input int sc,
                        input int cc, input int ea, input int ed);
        exp_t e;
        e.p = p; e.f = f; e.t = t;
        e.sc = 16'(sc); e.cc = 16'(cc);
        e.ea = 32'(ea); e.ed = 32'(ed);
        sb.push_back(e);
    endtask

    // Monitor: one verdict per rising edge of done.
    always @(negedge clk) begin
        if (done === 1'b1 && done_q === 1'b0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_verdict: got pass=%0b fail=%0b timeout=%0b, expected none",
                         pass, fail, timeout);
            end else begin
                mon_e = sb.pop_front();
                chk("v_pass", {31'd0, pass}, {31'd0, mon_e.p});
                chk("v_fail", {31'd0, fail}, {31'd0, mon_e.f});
                chk("v_timeout", {31'd0, timeout}, {31'd0, mon_e.t});
                chk("v_store_count", {16'd0, store_count}, {16'd0, mon_e.sc});
                chk("v_cycle_count", {16'd0, cycle_count}, {16'd0, mon_e.cc});
                chk("v_err_addr", err_addr, mon_e.ea);
                chk("v_err_data", err_data, mon_e.ed);
            end
        end
        done_q = done;
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            memwrite = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
        chk({tag, "_fail"}, {31'd0, fail}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
        chk({tag, "_store_count"}, {16'd0, store_count}, 32'd0);
        chk({tag, "_cycle_count"}, {16'd0, cycle_count}, 32'd0);
        chk({tag, "_err_addr"}, err_addr, 32'd0);
        chk({tag, "_err_data"}, err_data, 32'd0);
    endtask

    // Reset asserted mid-cycle, checked before the next edge, released just
    // after a negedge so the following posedge is RUN edge 1.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        reset    = 1'b1;
        memwrite = 1'b0;
        #2;
        check_zero(tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Wait (bounded) for the monitor to consume all pending verdicts.
    task automatic drain(input string tag);
        int k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_no_verdict: got %0d pending, expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        reset     = 1'b1;
        memwrite  = 1'b0;
        dataadr   = 32'd0;
        writedata = 32'd0;
        #10;
        check_zero("por");
        #12;
        reset = 1'b0;   // released at 22 ns; edge at 25 ns is RUN edge 1

        // Ignored scratch stores then the pass store on RUN edge 4.
        push(1'b1, 1'b0, 1'b0, 3, 4, 84, 7);
        store(32'd80, 32'd0);
        store(32'd80, 32'd3);
        store(32'd84, 32'd7);
        idle(1);
        drain("pass_seq");
        idle(2);
        chk("hold_pass", {31'd0, pass}, 32'd1);
        chk("hold_store_count", {16'd0, store_count}, 32'd3);
        chk("hold_cycle_count", {16'd0, cycle_count}, 32'd4);

        // Mid-cycle reset after pass, then a fresh pass.
        do_reset("rst_after_pass");
        push(1'b1, 1'b0, 1'b0, 1, 2, 84, 7);
        store(32'd84, 32'd7);
        idle(1);
        drain("repass");

        // Wrong data at the pass address; later good store is ignored.
        do_reset("rst_a");
        push(1'b0, 1'b1, 1'b0, 1, 2, 84, 6);
        store(32'd84, 32'd6);
        idle(1);
        drain("bad_data");
        store(32'd84, 32'd7);
        idle(1);
        chk("sticky_fail", {31'd0, fail}, 32'd1);
        chk("sticky_pass", {31'd0, pass}, 32'd0);
        chk("sticky_err_data", err_data, 32'd6);
        chk("sticky_store_count", {16'd0, store_count}, 32'd1);
        chk("sticky_cycle_count", {16'd0, cycle_count}, 32'd2);

        // Misaligned address.
        do_reset("rst_b");
        push(1'b0, 1'b1, 1'b0, 1, 2, 82, 7);
        store(32'd82, 32'd7);
        idle(1);
        drain("misaligned");

        // Aligned but unknown address.
        do_reset("rst_c");
        push(1'b0, 1'b1, 1'b0, 1, 2, 96, 7);
        store(32'd96, 32'd7);
        idle(1);
        drain("bad_addr");

        // No stores: timeout after RUN edge 10.
        do_reset("rst_d");
        push(1'b0, 1'b0, 1'b1, 0, 10, 0, 0);
        drain("timeout");

        // Pass store on RUN edge 10 beats the timeout.
        do_reset("rst_e");
        push(1'b1, 1'b0, 1'b0, 1, 10, 84, 7);
        idle(8);
        store(32'd84, 32'd7);
        idle(1);
        drain("pass_at_limit");

        // Pass address/data present but no strobe: stays in RUN.
        dataadr   = 32'd84;
        writedata = 32'd7;
        do_reset("rst_f");
        idle(4);
        @(negedge clk);
        chk("nostrobe_done", {31'd0, done}, 32'd0);
        chk("nostrobe_store_count", {16'd0, store_count}, 32'd0);
        chk("nostrobe_cycle_count", {16'd0, cycle_count}, 32'd5);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
